// File: rtl/pio_cmd_initiator.sv
// rtl/pio_cmd_initiator.sv - initiator side of the ENABLE/DONE PIO command protocol
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     command request handshake (req_cmd, req_addr, req_data)
//   soft_reset_req          request a reset pulse on control bit 31 (honoured in IDLE only)
//   pio_control_out         {not_reset, enable, 9'b0, cmd[5:0], addr[14:0]}
//   pio_data_out            write data word
//   pio_status_in           coprocessor status, bit1 = DONE, bit0 = system active
//   busy                    high whenever the sequencer is not idle
//   rsp_valid               one-cycle completion pulse with rsp_error / rsp_timeout / rsp_status
module pio_cmd_initiator #(
   parameter int unsigned HOLD_CYCLES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned RST_CYCLES     = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_cmd,
   input  logic [14:0] req_addr,
   input  logic [31:0] req_data,
   input  logic        soft_reset_req,
   output logic [31:0] pio_control_out,
   output logic [31:0] pio_data_out,
   input  logic [31:0] pio_status_in,
   output logic        busy,
   output logic        rsp_valid,
   output logic        rsp_error,
   output logic        rsp_timeout,
   output logic [31:0] rsp_status
);

   localparam logic [5:0]  CMD_IMGRAM  = 6'h01;
   localparam logic [5:0]  CMD_REGCTRL = 6'h02;
   localparam logic [5:0]  CMD_START   = 6'h04;

   localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_RST_PULSE,
      ST_IDLE,
      ST_SETUP,
      ST_ASSERT,
      ST_WAIT_DONE,
      ST_RELEASE_WAIT,
      ST_RELEASE
   } state_t;

   state_t      state;
   state_t      next_state;

   logic [31:0] cnt;
   logic [5:0]  cmd_q;
   logic [14:0] addr_q;
   logic [31:0] data_q;

   // status_meta is the first (metastable) stage; status_sync is safe to use
   logic [1:0]  status_meta;
   logic [1:0]  status_sync;
   logic        done_s;
   logic        active_s;

   logic        cmd_legal;
   logic        cnt_clr;
   logic        latch_req;
   logic        clear_bus;
   logic        rsp_fire;
   logic        err_fire;
   logic        to_fire;
   logic        enable;
   logic        show_cmd;

   assign done_s    = status_sync[1];
   assign active_s  = status_sync[0];
   assign cmd_legal = (req_cmd == CMD_IMGRAM) || (req_cmd == CMD_REGCTRL) || (req_cmd == CMD_START);

   // ------------------------------------------------------------------
   // Status synchronizer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         status_meta <= 2'b00;
         status_sync <= 2'b00;
      end else begin
         status_meta <= pio_status_in[1:0];
         status_sync <= status_meta;
      end
   end

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_RST_PULSE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state and control strobes
   // ------------------------------------------------------------------
   always_comb begin
      next_state = state;
      cnt_clr    = 1'b0;
      latch_req  = 1'b0;
      clear_bus  = 1'b0;
      rsp_fire   = 1'b0;
      err_fire   = 1'b0;
      to_fire    = 1'b0;

      case (state)
         ST_RST_PULSE: begin
            if (cnt == RST_LAST) begin
               next_state = ST_IDLE;
               cnt_clr    = 1'b1;
            end
         end

         ST_IDLE: begin
            if (soft_reset_req) begin
               next_state = ST_RST_PULSE;
               cnt_clr    = 1'b1;
               clear_bus  = 1'b1;
            end else if (req_valid) begin
               if (cmd_legal) begin
                  latch_req  = 1'b1;
                  next_state = ST_SETUP;
               end else begin
                  // Illegal command: answer next cycle, leave the bus alone
                  rsp_fire = 1'b1;
                  err_fire = 1'b1;
               end
            end
         end

         ST_SETUP: begin
            next_state = ST_ASSERT;
            cnt_clr    = 1'b1;
         end

         ST_ASSERT: begin
            if (cmd_q == CMD_START) begin
               next_state = ST_WAIT_DONE;
               cnt_clr    = 1'b1;
            end else if (cnt == HOLD_LAST) begin
               next_state = ST_RELEASE;
               rsp_fire   = 1'b1;
            end
         end

         ST_WAIT_DONE: begin
            // DONE wins over a timeout landing on the same cycle
            if (done_s) begin
               next_state = ST_RELEASE_WAIT;
               cnt_clr    = 1'b1;
            end else if (cnt == TIMEOUT_LAST) begin
               next_state = ST_IDLE;
               rsp_fire   = 1'b1;
               to_fire    = 1'b1;
            end
         end

         ST_RELEASE_WAIT: begin
            if (!done_s) begin
               next_state = ST_RELEASE;
               rsp_fire   = 1'b1;
            end else if (cnt == TIMEOUT_LAST) begin
               next_state = ST_IDLE;
               rsp_fire   = 1'b1;
               to_fire    = 1'b1;
            end
         end

         ST_RELEASE: begin
            next_state = ST_IDLE;
         end

         default: begin
            next_state = ST_RST_PULSE;
            cnt_clr    = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Counter and request latches
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= 32'd0;
         cmd_q  <= 6'd0;
         addr_q <= 15'd0;
         data_q <= 32'd0;
      end else begin
         if (cnt_clr) begin
            cnt <= 32'd0;
         end else if (state != ST_IDLE) begin
            cnt <= cnt + 32'd1;
         end

         if (latch_req) begin
            cmd_q  <= req_cmd;
            addr_q <= req_addr;
            data_q <= req_data;
         end else if (clear_bus) begin
            // The reset pulse presents an all-zero control word
            addr_q <= 15'd0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Response registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid   <= 1'b0;
         rsp_error   <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_status  <= 32'd0;
      end else begin
         rsp_valid   <= rsp_fire;
         rsp_error   <= err_fire;
         rsp_timeout <= to_fire;
         if (rsp_fire) begin
            rsp_status <= {pio_status_in[31:2], done_s, active_s};
         end
      end
   end

   // ------------------------------------------------------------------
   // Bus outputs, decoded from registered state only
   // ------------------------------------------------------------------
   // cmd is visible from SETUP through RELEASE_WAIT and dropped in RELEASE,
   // so ENABLE never coincides with a field change.
   always_comb begin
      enable   = (state == ST_ASSERT) || (state == ST_WAIT_DONE);
      show_cmd = (state == ST_SETUP) || (state == ST_ASSERT) ||
                 (state == ST_WAIT_DONE) || (state == ST_RELEASE_WAIT);
      pio_control_out = {(state != ST_RST_PULSE), enable, 9'd0,
                         (show_cmd ? cmd_q : 6'd0), addr_q};
   end

   assign pio_data_out = data_q;
   assign busy         = (state != ST_IDLE);
   assign req_ready    = (state == ST_IDLE) && !soft_reset_req;

endmodule

// File: tb/tb_pio_cmd_initiator.sv
// tb/tb_pio_cmd_initiator.sv - self-checking bench for pio_cmd_initiator
module tb_pio_cmd_initiator;

   localparam int HOLD = 2;
   localparam int TO   = 50;
   localparam int RSTC = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_cmd;
   logic [14:0] req_addr;
   logic [31:0] req_data;
   logic        soft_reset_req;
   logic [31:0] pio_control_out;
   logic [31:0] pio_data_out;
   logic [31:0] pio_status_in;
   logic        busy;
   logic        rsp_valid;
   logic        rsp_error;
   logic        rsp_timeout;
   logic [31:0] rsp_status;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pio_cmd_initiator #(
      .HOLD_CYCLES   (HOLD),
      .TIMEOUT_CYCLES(TO),
      .RST_CYCLES    (RSTC)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_cmd        (req_cmd),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .soft_reset_req (soft_reset_req),
      .pio_control_out(pio_control_out),
      .pio_data_out   (pio_data_out),
      .pio_status_in  (pio_status_in),
      .busy           (busy),
      .rsp_valid      (rsp_valid),
      .rsp_error      (rsp_error),
      .rsp_timeout    (rsp_timeout),
      .rsp_status     (rsp_status)
   );

   typedef struct {
      logic [5:0]  cmd;
      logic [14:0] addr;
      logic [31:0] data;
      logic        illegal;
      logic [31:0] ctl_setup;    // for illegal commands: the untouched idle word
      logic [31:0] ctl_assert;
      logic [31:0] ctl_release;
      logic [31:0] data_exp;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{6'h03, 15'h0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0000};
      vecs[1] = '{6'h00, 15'h0011, 32'h0000_0022, 1'b1, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0000};
      vecs[2] = '{6'h01, 15'h1234, 32'h0000_00AB, 1'b0, 32'h8000_9234, 32'hC000_9234, 32'h8000_1234, 32'h0000_00AB};
      vecs[3] = '{6'h3F, 15'h0001, 32'h0000_0001, 1'b1, 32'h8000_1234, 32'h0, 32'h0, 32'h0000_00AB};
      vecs[4] = '{6'h02, 15'h0003, 32'hDEAD_BEEF, 1'b0, 32'h8001_0003, 32'hC001_0003, 32'h8000_0003, 32'hDEAD_BEEF};
      vecs[5] = '{6'h01, 15'h7FFF, 32'h0000_0055, 1'b0, 32'h8000_FFFF, 32'hC000_FFFF, 32'h8000_7FFF, 32'h0000_0055};

      reset_n        = 1'b0;
      req_valid      = 1'b0;
      req_cmd        = 6'd0;
      req_addr       = 15'd0;
      req_data       = 32'd0;
      soft_reset_req = 1'b0;
      pio_status_in  = 32'hCAFE_0001;

      // ---------------- reset ----------------
      repeat (3) tick();
      chk("reset ctl", pio_control_out, 32'h0);
      chk("reset data", pio_data_out, 32'h0);
      chk("reset busy", busy, 1);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset req_ready", req_ready, 0);
      reset_n = 1'b1;
      #1;
      chk("rst pulse ctl p0", pio_control_out, 32'h0);
      for (int i = 1; i < RSTC; i++) begin
         tick();
         chk($sformatf("rst pulse ctl p%0d", i), pio_control_out, 32'h0);
      end
      tick();
      chk("post reset ctl", pio_control_out, 32'h8000_0000);
      chk("post reset req_ready", req_ready, 1);
      chk("post reset busy", busy, 0);

      // ---------------- table-driven commands ----------------
      for (int v = 0; v < 6; v++) begin
         req_valid = 1'b1;
         req_cmd   = vecs[v].cmd;
         req_addr  = vecs[v].addr;
         req_data  = vecs[v].data;
         #1;
         chk($sformatf("v%0d req_ready", v), req_ready, 1);
         chk($sformatf("v%0d idle busy", v), busy, 0);
         tick();
         req_valid = 1'b0;
         if (vecs[v].illegal) begin
            chk($sformatf("v%0d ill ctl", v), pio_control_out, vecs[v].ctl_setup);
            chk($sformatf("v%0d ill data", v), pio_data_out, vecs[v].data_exp);
            chk($sformatf("v%0d ill rsp_valid", v), rsp_valid, 1);
            chk($sformatf("v%0d ill rsp_error", v), rsp_error, 1);
            chk($sformatf("v%0d ill rsp_timeout", v), rsp_timeout, 0);
            chk($sformatf("v%0d ill busy", v), busy, 0);
            tick();
            chk($sformatf("v%0d ill rsp_valid drop", v), rsp_valid, 0);
            chk($sformatf("v%0d ill rsp_error drop", v), rsp_error, 0);
         end else begin
            chk($sformatf("v%0d setup ctl", v), pio_control_out, vecs[v].ctl_setup);
            chk($sformatf("v%0d setup data", v), pio_data_out, vecs[v].data_exp);
            chk($sformatf("v%0d setup busy", v), busy, 1);
            chk($sformatf("v%0d setup rsp_valid", v), rsp_valid, 0);
            for (int h = 0; h < HOLD; h++) begin
               tick();
               chk($sformatf("v%0d assert%0d ctl", v, h), pio_control_out, vecs[v].ctl_assert);
               chk($sformatf("v%0d assert%0d rsp_valid", v, h), rsp_valid, 0);
            end
            tick();
            chk($sformatf("v%0d release ctl", v), pio_control_out, vecs[v].ctl_release);
            chk($sformatf("v%0d release rsp_valid", v), rsp_valid, 1);
            chk($sformatf("v%0d release rsp_error", v), rsp_error, 0);
            chk($sformatf("v%0d release rsp_timeout", v), rsp_timeout, 0);
            chk($sformatf("v%0d release rsp_status", v), rsp_status, 32'hCAFE_0001);
            tick();
            chk($sformatf("v%0d idle rsp_valid", v), rsp_valid, 0);
            chk($sformatf("v%0d idle ctl", v), pio_control_out, vecs[v].ctl_release);
         end
      end

      // ---------------- start with DONE handshake ----------------
      req_valid = 1'b1;
      req_cmd   = 6'h04;
      req_addr  = 15'h0000;
      req_data  = 32'h0;
      #1;
      chk("start req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         logic [31:0] exp_ctl;
         if (k == 12) pio_status_in[1] = 1'b1;
         if (k == 18) pio_status_in[1] = 1'b0;
         if (k == 1)       exp_ctl = 32'h8002_0000;
         else if (k <= 14) exp_ctl = 32'hC002_0000;
         else if (k <= 20) exp_ctl = 32'h8002_0000;
         else              exp_ctl = 32'h8000_0000;
         chk($sformatf("start k%0d ctl", k), pio_control_out, exp_ctl);
         chk($sformatf("start k%0d rsp_valid", k), rsp_valid, (k == 21) ? 1 : 0);
         if (k == 21) begin
            chk("start rsp_status", rsp_status, 32'hCAFE_0001);
            chk("start rsp_timeout", rsp_timeout, 0);
            chk("start rsp_error", rsp_error, 0);
         end
         tick();
      end
      chk("start done busy", busy, 0);

      // ---------------- timeout, then immediate next request ----------------
      req_valid = 1'b1;
      req_cmd   = 6'h04;
      req_addr  = 15'h0005;
      #1;
      tick();
      req_valid = 1'b0;
      for (int k = 1; k <= 53; k++) begin
         logic [31:0] exp_ctl;
         if (k == 1)       exp_ctl = 32'h8002_0005;
         else if (k <= 52) exp_ctl = 32'hC002_0005;
         else              exp_ctl = 32'h8000_0005;
         if (k == 53) begin
            req_valid = 1'b1;
            req_cmd   = 6'h02;
            req_addr  = 15'h0001;
            req_data  = 32'h1234_5678;
            #1;
            chk("timeout rsp_timeout", rsp_timeout, 1);
            chk("timeout rsp_error", rsp_error, 0);
            chk("timeout rsp_status", rsp_status, 32'hCAFE_0001);
            chk("timeout req_ready", req_ready, 1);
            chk("timeout busy", busy, 0);
         end
         chk($sformatf("timeout k%0d ctl", k), pio_control_out, exp_ctl);
         chk($sformatf("timeout k%0d rsp_valid", k), rsp_valid, (k == 53) ? 1 : 0);
         tick();
      end
      req_valid = 1'b0;
      chk("after timeout setup ctl", pio_control_out, 32'h8001_0001);
      chk("after timeout setup data", pio_data_out, 32'h1234_5678);
      repeat (HOLD + 2) tick();
      chk("after timeout idle busy", busy, 0);
      chk("after timeout idle ctl", pio_control_out, 32'h8000_0001);

      // ---------------- soft reset priority ----------------
      soft_reset_req = 1'b1;
      req_valid      = 1'b1;
      req_cmd        = 6'h01;
      req_addr       = 15'h0ABC;
      req_data       = 32'h0000_0011;
      #1;
      chk("soft req_ready", req_ready, 0);
      tick();
      soft_reset_req = 1'b0;
      for (int p = 1; p <= RSTC; p++) begin
         #1;
         chk($sformatf("soft p%0d ctl[31:30]", p), {30'd0, pio_control_out[31:30]}, 32'h0);
         chk($sformatf("soft p%0d req_ready", p), req_ready, 0);
         chk($sformatf("soft p%0d busy", p), busy, 1);
         chk($sformatf("soft p%0d rsp_valid", p), rsp_valid, 0);
         tick();
      end
      chk("soft end bit31", pio_control_out[31], 1);
      chk("soft end req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("soft accept setup ctl", pio_control_out, 32'h8000_8ABC);
      repeat (HOLD + 1) tick();
      chk("soft accept rsp_valid", rsp_valid, 1);
      tick();

      // ---------------- async reset mid WAIT_DONE ----------------
      req_valid = 1'b1;
      req_cmd   = 6'h04;
      req_addr  = 15'h0077;
      #1;
      tick();
      req_valid = 1'b0;
      repeat (3) tick();
      chk("async pre ctl", pio_control_out, 32'hC002_0077);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async ctl", pio_control_out, 32'h0);
      chk("async busy", busy, 1);
      chk("async rsp_valid", rsp_valid, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("async hold%0d rsp_valid", i), rsp_valid, 0);
         chk($sformatf("async hold%0d ctl", i), pio_control_out, 32'h0);
      end
      reset_n = 1'b1;
      repeat (RSTC) tick();
      chk("async recover ctl", pio_control_out, 32'h8000_0000);
      chk("async recover rsp_valid", rsp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pio_cmd_initiator.md
Name: pio_cmd_initiator

Overview:
- Initiator side of the ENABLE/DONE PIO command protocol.
- Accepts command requests (write image RAM, write register controller, start processing) on a valid/ready interface, then drives the 32-bit control and data words that the coprocessor decodes.
- Sequences ENABLE, waits for the DONE status bit where required, and returns a response.
- Used on-fabric as a hardware replay/loader master and as the protocol driver in system benches.

Parameters:
- HOLD_CYCLES, 2: cycles ENABLE stays high for write commands (01h, 02h); minimum 1.
- TIMEOUT_CYCLES, 1000000: maximum cycles spent in either DONE wait before aborting; 32-bit counter.
- RST_CYCLES, 4: cycles bit 31 is held low during a reset pulse; minimum 1.

Ports:
- clk, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted when req_valid & req_ready.
- req_cmd, in, 6: 01h = IMGRAM write, 02h = REGCTRL write, 04h = start processing.
- req_addr, in, 15: control[14:0]; for REGCTRL, bits [1:0] select the register.
- req_data, in, 32: data word (IMGRAM uses [7:0]).
- soft_reset_req, in, 1: request a reset pulse on bit 31.
- pio_control_out, out, 32: bit31 = not-reset, bit30 = ENABLE, [20:15] = cmd, [14:0] = address; all other bits 0.
- pio_data_out, out, 32: write data word.
- pio_status_in, in, 32: status word; bit1 = DONE, bit0 = system active.
- busy, out, 1: high whenever state is not IDLE.
- rsp_valid, out, 1: one-cycle completion pulse.
- rsp_error, out, 1: illegal command; valid with rsp_valid.
- rsp_timeout, out, 1: DONE wait expired; valid with rsp_valid.
- rsp_status, out, 32: synchronized status captured at completion.

Behaviour:
- **Reset (reset_n=0):** async clear. pio_control_out=0 (target held in reset), pio_data_out=0, rsp_* = 0, counters = 0, state = RST_PULSE.
- **Status sync:** pio_status_in[1:0] passes through a 2-flop synchronizer giving done_s and active_s. rsp_status = {pio_status_in[31:2] sampled, done_s, active_s}.
- **RST_PULSE:** bit31=0, ENABLE=0, busy=1. After RST_CYCLES cycles, set bit31=1 and go to IDLE. A reset_n assertion at any point restarts this from the reset values.
- **IDLE:** req_ready = ~soft_reset_req (combinational); ENABLE=0; bit31=1.
  - soft_reset_req has priority: go to RST_PULSE and accept no request that cycle.
  - On accept: latch cmd/addr/data.
    - Illegal cmd (not 01h/02h/04h): next cycle rsp_valid=1 and rsp_error=1; bus untouched; remain in IDLE.
    - Legal cmd: go to SETUP.
- **SETUP (1 cycle):** drive cmd, addr and data with ENABLE=0 so fields are stable before the strobe.
- **ASSERT:** ENABLE=1.
  - Writes: hold for exactly HOLD_CYCLES cycles, then go to RELEASE.
  - Start (04h): go to WAIT_DONE after 1 cycle.
- **WAIT_DONE:** ENABLE stays 1 until done_s=1, then go to RELEASE_WAIT.
- **RELEASE_WAIT:** ENABLE=0, cmd/addr held; wait for done_s=0, then go to RELEASE.
- **Timeout:** the timeout counter is cleared on entry to WAIT_DONE and on entry to RELEASE_WAIT. If it reaches TIMEOUT_CYCLES in either state: ENABLE=0, rsp_valid=1, rsp_timeout=1, rsp_status captured, go to IDLE.
- **RELEASE (1 cycle):** ENABLE=0, cmd field=0, address held. Pulse rsp_valid (rsp_error=0, rsp_timeout=0) and capture rsp_status. Go to IDLE; the next request can be accepted in that IDLE cycle.
- **Ignored outside IDLE:** soft_reset_req and req_valid.
- **Latency:** write accepted at cycle T → ENABLE high T+2 .. T+1+HOLD_CYCLES → rsp_valid at T+2+HOLD_CYCLES.
- **Stale DONE:** if done_s is already 1 on entry to WAIT_DONE, the start completes immediately. Handling stale DONE is the caller's responsibility.
- **ENABLE invariant:** ENABLE is never 1 while bit31=0, nor in the same cycle cmd/addr change.

Test Plan:
- **Reset:** release reset_n with RST_CYCLES=4 → pio_control_out=0 for 4 cycles after release, then 8000_0000h; req_ready=1.
- **IMGRAM write:** req cmd=01h, addr=1234h, data=ABh accepted at T → pio_control_out=8000_9234h at T+1, C000_9234h at T+2 and T+3, rsp_valid at T+4 with no error.
- **Start with DONE:** req cmd=04h; status bit1 rises 10 cycles after ENABLE and falls 3 cycles after ENABLE drops → ENABLE (C002_0000h) lasts until done_s=1. Then 8002_0000h is held until done_s=0. rsp_valid then fires with rsp_status[1]=0.
- **Timeout:** TIMEOUT_CYCLES=50, start with bit1 never rising → ENABLE drops after 50 WAIT_DONE cycles; rsp_valid=1, rsp_timeout=1; next request accepted.
- **Illegal cmd:** req cmd=03h → pio_control_out stays 8000_0000h; rsp_valid with rsp_error=1 one cycle after accept.
- **Soft reset priority / async reset:**
  - soft_reset_req=1 together with req_valid in IDLE → req_ready=0; bit31 low for RST_CYCLES; request accepted afterwards.
  - reset_n asserted mid WAIT_DONE → pio_control_out=0 immediately; no rsp_valid.
